// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch slice: word type, fetch FSM states and word size.
// Used by fetch_unit and its optional branch target buffer (FETCH_BTB_EN).
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      REDIR  = 2'b01,
      HALTED = 2'b10
   } fetch_state_t;

   localparam word_t WORD_BYTES = 32'd4;

   // Instruction addresses are word aligned; low two bits are forced to zero.
   function automatic word_t align_word(input word_t addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer for fetch_unit, present only when FETCH_BTB_EN is defined.
// Lookup is combinational from stored state, so a same-cycle update is seen one cycle later.
module fetch_btb
   import cpu_types_pkg::*;
#(
   parameter int ENTRIES = 4
) (
   input  logic  clk,
   input  logic  nRST,
   input  word_t lookup_pc,
   output logic  hit,
   output word_t target,
   input  logic  upd_valid,
   input  logic  upd_taken,
   input  word_t upd_pc,
   input  word_t upd_target
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = 32 - IDX - 2;

   logic [ENTRIES-1:0] valid_r;
   logic [TAG_W-1:0]   tag_r    [ENTRIES];
   word_t              target_r [ENTRIES];

   logic [IDX-1:0]     rd_idx_s;
   logic [IDX-1:0]     wr_idx_s;
   logic [TAG_W-1:0]   rd_tag_s;
   logic [TAG_W-1:0]   wr_tag_s;
   logic               unused_s;

   assign rd_idx_s = lookup_pc[IDX+1:2];
   assign rd_tag_s = lookup_pc[31:IDX+2];
   assign wr_idx_s = upd_pc[IDX+1:2];
   assign wr_tag_s = upd_pc[31:IDX+2];
   assign unused_s = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

   assign hit    = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
   assign target = target_r[rd_idx_s];

   // Entry update: taken resolutions allocate, not-taken ones invalidate a matching entry.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         valid_r <= {ENTRIES{1'b0}};
         for (int i = 0; i < ENTRIES; i++) begin
            tag_r[i]    <= {TAG_W{1'b0}};
            target_r[i] <= 32'h0000_0000;
         end
      end else if (upd_valid) begin
         if (upd_taken) begin
            valid_r[wr_idx_s]  <= 1'b1;
            tag_r[wr_idx_s]    <= wr_tag_s;
            target_r[wr_idx_s] <= align_word(upd_target);
         end else if (valid_r[wr_idx_s] && (tag_r[wr_idx_s] == wr_tag_s)) begin
            valid_r[wr_idx_s]  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, redirect/halt FSM and icache request.
// Define FETCH_BTB_EN to add a fetch_btb predictor for the sequential-advance path.
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT     = 32'h0000_0000,
   parameter int    BTB_ENTRIES = 4
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] iload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        freeze,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   input  logic        resolve_valid,
   input  logic        resolve_taken,
   input  logic [31:0] resolve_pc,
   input  logic [31:0] resolve_target,
   output logic [31:0] instr_out,
   output logic [31:0] npc_out,
   output logic        pred_taken_out,
   output logic        flush_out
);

   fetch_state_t state_r, state_next_s;
   word_t        pc_r, pc_next_s;
   word_t        saved_pc_r, saved_next_s;
   word_t        pc_plus4_s;
   word_t        redirect_aligned_s;
   word_t        btb_target_s;
   logic         btb_hit_s;
   logic         flush_s;
   logic         pred_taken_s;
   logic         unused_s;

   assign pc_plus4_s         = pc_r + WORD_BYTES;
   assign redirect_aligned_s = align_word(redirect_pc);
   assign unused_s           = ^{redirect_pc[1:0]};

`ifdef FETCH_BTB_EN
   fetch_btb #(
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk        (clk),
      .nRST       (nRST),
      .lookup_pc  (pc_r),
      .hit        (btb_hit_s),
      .target     (btb_target_s),
      .upd_valid  (resolve_valid),
      .upd_taken  (resolve_taken),
      .upd_pc     (resolve_pc),
      .upd_target (resolve_target)
   );
`else
   localparam int unused_btb_entries = BTB_ENTRIES;
   logic unused_resolve_s;

   assign btb_hit_s        = 1'b0;
   assign btb_target_s     = 32'h0000_0000;
   assign unused_resolve_s = ^{resolve_valid, resolve_taken, resolve_pc, resolve_target};
`endif

   // Next-state, next-PC and flush/prediction decode.
   always_comb begin
      state_next_s = state_r;
      pc_next_s    = pc_r;
      saved_next_s = saved_pc_r;
      flush_s      = 1'b0;
      pred_taken_s = 1'b0;
      case (state_r)
         RUN: begin
            if (halt) begin
               state_next_s = HALTED;
            end else if (redirect) begin
               if (ihit) begin
                  pc_next_s = redirect_aligned_s;
                  flush_s   = 1'b1;
               end else begin
                  saved_next_s = redirect_aligned_s;
                  state_next_s = REDIR;
               end
            end else if (freeze) begin
               pc_next_s = pc_r;
            end else if (ihit) begin
               if (btb_hit_s) begin
                  pc_next_s    = btb_target_s;
                  pred_taken_s = 1'b1;
               end else begin
                  pc_next_s = pc_plus4_s;
               end
            end else begin
               pc_next_s = pc_r;
            end
         end
         REDIR: begin
            // A fresh redirect supersedes the pending target.
            if (halt) begin
               state_next_s = HALTED;
            end else if (redirect && ihit) begin
               pc_next_s    = redirect_aligned_s;
               flush_s      = 1'b1;
               state_next_s = RUN;
            end else if (redirect) begin
               saved_next_s = redirect_aligned_s;
            end else if (ihit) begin
               pc_next_s    = saved_pc_r;
               flush_s      = 1'b1;
               state_next_s = RUN;
            end else begin
               pc_next_s = pc_r;
            end
         end
         HALTED: begin
            state_next_s = HALTED;
         end
         default: begin
            state_next_s = RUN;
         end
      endcase
   end

   // State, PC and pending-redirect registers.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_r    <= RUN;
         pc_r       <= align_word(PC_INIT);
         saved_pc_r <= 32'h0000_0000;
      end else begin
         state_r    <= state_next_s;
         pc_r       <= pc_next_s;
         saved_pc_r <= saved_next_s;
      end
   end

   assign imemREN        = (state_r != HALTED);
   assign imemaddr       = pc_r;
   assign instr_out      = iload;
   assign npc_out        = pc_plus4_s;
   assign pred_taken_out = pred_taken_s;
   assign flush_out      = flush_s & nRST;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a driver pushes hand-computed expectations per cycle,
// a monitor pops and compares them against the DUT outputs. Covers FETCH_BTB_EN when defined.
module tb_fetch_unit;

`ifdef FETCH_BTB_EN
   localparam bit BTB = 1'b1;
`else
   localparam bit BTB = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] npc;
      logic [31:0] instr;
      logic        flush;
      logic        ren;
      logic        pred;
      string       name;
   } exp_t;

   logic        clk;
   logic        nRST;
   logic        ihit;
   logic [31:0] iload;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        freeze;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        resolve_valid;
   logic        resolve_taken;
   logic [31:0] resolve_pc;
   logic [31:0] resolve_target;
   logic [31:0] instr_out;
   logic [31:0] npc_out;
   logic        pred_taken_out;
   logic        flush_out;

   exp_t        sb[$];
   int          compared;
   int          mismatched;

   logic        rv_pend;
   logic        rt_pend;
   logic [31:0] rpc_pend;
   logic [31:0] rtgt_pend;

   fetch_unit dut (
      .clk            (clk),
      .nRST           (nRST),
      .ihit           (ihit),
      .iload          (iload),
      .imemREN        (imemREN),
      .imemaddr       (imemaddr),
      .freeze         (freeze),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .resolve_valid  (resolve_valid),
      .resolve_taken  (resolve_taken),
      .resolve_pc     (resolve_pc),
      .resolve_target (resolve_target),
      .instr_out      (instr_out),
      .npc_out        (npc_out),
      .pred_taken_out (pred_taken_out),
      .flush_out      (flush_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic set_resolve(input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
      rv_pend   = 1'b1;
      rt_pend   = taken;
      rpc_pend  = pc;
      rtgt_pend = tgt;
   endtask

   // One cycle of stimulus plus the outputs expected while it is applied.
   task automatic step(input logic n, input logic ih, input logic fz, input logic rd,
                       input logic [31:0] rpc, input logic hl,
                       input logic [31:0] ea, input logic ef, input logic er,
                       input logic ep, input string nm);
      exp_t e;
      @(negedge clk);
      nRST           = n;
      ihit           = ih;
      freeze         = fz;
      redirect       = rd;
      redirect_pc    = rpc;
      halt           = hl;
      resolve_valid  = rv_pend;
      resolve_taken  = rt_pend;
      resolve_pc     = rpc_pend;
      resolve_target = rtgt_pend;
      rv_pend        = 1'b0;
      iload          = $urandom;
      e.addr  = ea;
      e.npc   = ea + 32'd4;
      e.instr = iload;
      e.flush = ef;
      e.ren   = er;
      e.pred  = ep;
      e.name  = nm;
      sb.push_back(e);
   endtask

   // Monitor: compare every presented cycle against the oldest expectation.
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         compared++;
         if (imemaddr !== e.addr || npc_out !== e.npc || instr_out !== e.instr ||
             flush_out !== e.flush || imemREN !== e.ren || pred_taken_out !== e.pred) begin
            mismatched++;
            $display("FAIL %s: got addr=%h npc=%h instr=%h flush=%b ren=%b pred=%b, want addr=%h npc=%h instr=%h flush=%b ren=%b pred=%b",
                     e.name, imemaddr, npc_out, instr_out, flush_out, imemREN, pred_taken_out,
                     e.addr, e.npc, e.instr, e.flush, e.ren, e.pred);
         end
      end
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      rv_pend    = 1'b0;
      rt_pend    = 1'b0;
      rpc_pend   = 32'h0;
      rtgt_pend  = 32'h0;
      nRST = 1'b0; ihit = 1'b0; iload = 32'h0; freeze = 1'b0; redirect = 1'b0;
      redirect_pc = 32'h0; halt = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0;
      resolve_pc = 32'h0; resolve_target = 32'h0;

      //    nRST  ihit  frz   rdir  redirect_pc   halt  exp_addr               flush ren   pred
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_0000,         1'b0, 1'b1, 1'b0, "reset");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000,         1'b0, 1'b1, 1'b0, "seq0");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0004,         1'b0, 1'b1, 1'b0, "seq4");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0008,         1'b0, 1'b1, 1'b0, "seq8");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_000C,         1'b0, 1'b1, 1'b0, "seq12");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0000_0010,         1'b0, 1'b1, 1'b0, "freeze_hold");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0010,         1'b0, 1'b1, 1'b0, "unfreeze");
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0014,         1'b0, 1'b1, 1'b0, "nohit_hold");
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0043, 1'b0, 32'h0000_0014,         1'b1, 1'b1, 1'b0, "redir_hit");
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0040,         1'b0, 1'b1, 1'b0, "redir_miss");
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0040,         1'b0, 1'b1, 1'b0, "redir_wait1");
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0040,         1'b0, 1'b1, 1'b0, "redir_wait2");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0040,         1'b1, 1'b1, 1'b0, "redir_done");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0100,         1'b0, 1'b1, 1'b0, "redir_target");
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0104,         1'b0, 1'b1, 1'b0, "redir_a");
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0104,         1'b0, 1'b1, 1'b0, "redir_overwrite");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0104,         1'b1, 1'b1, 1'b0, "overwrite_done");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0300,         1'b0, 1'b1, 1'b0, "overwrite_target");
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0304,         1'b1, 1'b1, 1'b0, "to_top");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC,         1'b0, 1'b1, 1'b0, "wrap_npc");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000,         1'b0, 1'b1, 1'b0, "wrap_addr");
      set_resolve(1'b1, 32'h0000_0020, 32'h0000_0080);
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0004,         1'b1, 1'b1, 1'b0, "btb_train");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0020,         1'b0, 1'b1, BTB,  "btb_lookup");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, BTB ? 32'h80 : 32'h24, 1'b0, 1'b1, 1'b0, "btb_predicted");
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b0, BTB ? 32'h84 : 32'h28, 1'b1, 1'b1, 1'b0, "btb_refetch");
      set_resolve(1'b0, 32'h0000_0020, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0020,         1'b0, 1'b1, BTB,  "btb_same_cycle_old");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, BTB ? 32'h80 : 32'h24, 1'b0, 1'b1, 1'b0, "btb_old_target");
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b0, BTB ? 32'h84 : 32'h28, 1'b1, 1'b1, 1'b0, "btb_refetch2");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0020,         1'b0, 1'b1, 1'b0, "btb_cleared");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0024,         1'b0, 1'b1, 1'b0, "btb_fallthrough");
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0700, 1'b1, 32'h0000_0028,         1'b0, 1'b1, 1'b0, "halt_and_redir");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0028,         1'b0, 1'b0, 1'b0, "halted");
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0700, 1'b0, 32'h0000_0028,         1'b0, 1'b0, 1'b0, "halted_redir");
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000,         1'b0, 1'b1, 1'b0, "reset_from_halt");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000,         1'b0, 1'b1, 1'b0, "restart0");
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0600, 1'b0, 32'h0000_0004,         1'b0, 1'b1, 1'b0, "redir_pending");
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000,         1'b0, 1'b1, 1'b0, "reset_mid_redir");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000,         1'b0, 1'b1, 1'b0, "abandoned0");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0004,         1'b0, 1'b1, 1'b0, "abandoned4");
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0900, 1'b0, 32'h0000_0008,         1'b0, 1'b1, 1'b0, "redir_then_halt");
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008,         1'b0, 1'b1, 1'b0, "halt_in_redir");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0008,         1'b0, 1'b0, 1'b0, "halted_after_redir");

      repeat (2) @(negedge clk);
      #5;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
